// File: rtl/spmv_result_packer.sv
// spmv_result_packer
//   Packs a stream of FP16 row results into 256-bit SRAM words (16 lanes per word)
//   and writes each word to consecutive 5-bit word addresses, wrapping modulo 32.
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         synchronous active-high reset, highest priority
//   i_start       one-cycle pulse; begins a new result vector (honoured in IDLE/DONE only)
//   i_num_rows    rows expected in the vector, sampled on an accepted i_start
//   i_base_addr   first SRAM word address, sampled on an accepted i_start
//   i_valid       upstream row result valid
//   i_data        FP16 row result, stored unmodified
//   o_ready       packer accepts i_data this cycle (FILL only)
//   o_address     SRAM word address of the word being filled / written
//   o_wr_en       SRAM write strobe, one cycle per word
//   o_write_data  packed word during o_wr_en, zero otherwise
//   o_state       FSM state: 0 IDLE, 1 FILL, 2 WRITE, 3 DONE
//   o_count       rows accepted since the last start
//   o_done        all rows of the vector written
module spmv_result_packer (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [8:0]   i_num_rows,
  input  logic [4:0]   i_base_addr,
  input  logic         i_valid,
  input  logic [15:0]  i_data,
  output logic         o_ready,
  output logic [4:0]   o_address,
  output logic         o_wr_en,
  output logic [255:0] o_write_data,
  output logic [1:0]   o_state,
  output logic [8:0]   o_count,
  output logic         o_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [8:0]   num_rows_q, num_rows_d;
  logic [4:0]   addr_q, addr_d;
  logic [8:0]   count_q, count_d;
  logic [3:0]   lane_q, lane_d;
  logic [255:0] buf_q, buf_d;

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    addr_d     = addr_q;
    count_d    = count_q;
    lane_d     = lane_q;
    buf_d      = buf_q;

    case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          num_rows_d = i_num_rows;
          addr_d     = i_base_addr;
          count_d    = 9'd0;
          lane_d     = 4'd0;
          buf_d      = '0;
          // An empty vector completes immediately without touching the SRAM.
          state_d    = (i_num_rows == 9'd0) ? StDone : StFill;
        end
      end

      StFill: begin
        if (i_valid) begin
          buf_d[{lane_q, 4'b0000} +: 16] = i_data;
          count_d = count_q + 9'd1;
          lane_d  = lane_q + 4'd1;
          if (lane_q == 4'd15 || count_d == num_rows_q) begin
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        buf_d   = '0;
        lane_d  = 4'd0;
        addr_d  = addr_q + 5'd1;  // natural 5-bit wrap gives modulo-32 addressing
        state_d = (count_q == num_rows_q) ? StDone : StFill;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      num_rows_q <= 9'd0;
      addr_q     <= 5'd0;
      count_q    <= 9'd0;
      lane_q     <= 4'd0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      buf_q      <= buf_d;
    end
  end

  // Outputs are decoded from registered state only; no input-to-output paths.
  always_comb begin
    o_ready      = (state_q == StFill);
    o_wr_en      = (state_q == StWrite);
    o_done       = (state_q == StDone);
    o_state      = state_q;
    o_count      = count_q;
    o_address    = addr_q;
    o_write_data = (state_q == StWrite) ? buf_q : '0;
  end

endmodule

// File: doc/spmv_result_packer.md
SPMV_RESULT_PACKER -- requirements
Module: spmv_result_packer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high, ports i_clk and i_rst.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst  input  1  synchronous active-high reset.
REQ-004 i_start  input  1  one-cycle pulse; begins a new result vector.
REQ-005 i_num_rows  input  9  rows expected, 0..511; sampled on accepted i_start.
REQ-006 i_base_addr  input  5  first SRAM word address; sampled on accepted i_start.
REQ-007 i_valid  input  1  upstream row result valid.
REQ-008 i_data  input  16  FP16 row dot-product result; opaque, never modified.
REQ-009 o_ready  output  1  packer accepts i_data this cycle.
REQ-010 o_address  output  5  SRAM word address.
REQ-011 o_wr_en  output  1  SRAM write strobe, one cycle per word.
REQ-012 o_write_data  output  256  packed word, 16 FP16 lanes.
REQ-013 o_state  output  2  current FSM state encoding.
REQ-014 o_count  output  9  rows accepted since last start.
REQ-015 o_done  output  1  all rows written.

Function
REQ-016 SHALL implement states IDLE=0, FILL=1, WRITE=2, DONE=3; o_state shows the current state.
REQ-017 IDLE: o_ready=0; i_start -> FILL, latch num_rows/base_addr, clear o_count, lane counter, buffer; if i_num_rows=0 -> DONE directly, no write.
REQ-018 FILL: o_ready=1; a row is accepted only when i_valid & o_ready.
REQ-019 Accepted row k of current word SHALL be stored in lane k, bits [16k+15:16k]; lane 0 = first row of word.
REQ-020 Each accepted row SHALL increment o_count and the lane counter (0..15).
REQ-021 FILL -> WRITE when the accepted row fills lane 15 or makes o_count equal latched num_rows.
REQ-022 WRITE: o_wr_en=1 for exactly one cycle; o_ready=0; o_address = current word address; o_write_data = buffer, unfilled lanes zero.
REQ-023 After WRITE: buffer and lane counter cleared, word address += 1 modulo 32; -> DONE if o_count = num_rows, else -> FILL.
REQ-024 Latency: final row accepted cycle N -> o_wr_en cycle N+1 -> o_done=1 from cycle N+2.
REQ-025 DONE: o_done=1 held, o_ready=0; i_start restarts as in REQ-017.
REQ-026 i_start in FILL or WRITE SHALL be ignored.
REQ-027 i_valid high while o_ready=0 SHALL not be accepted; upstream holds data; no row lost or duplicated.
REQ-028 o_write_data SHALL be zero when o_wr_en=0.
REQ-029 All outputs SHALL be registered or derived only from registered state.

Reset
REQ-030 i_rst SHALL have priority over all inputs, including i_start.
REQ-031 On reset: state IDLE, o_ready=0, o_wr_en=0, o_address=0, o_write_data=0, o_count=0, o_done=0, o_state=0, buffer cleared.
REQ-032 Reset mid-FILL or mid-WRITE SHALL abort with no further o_wr_en; partial word discarded.

Verification
REQ-033 Reset: hold i_rst 3 cycles -> all outputs 0, o_state=0; i_valid pulses ignored.
REQ-034 Full word: start, num_rows=16, base=0, 16 rows of 16'h3C00 back-to-back -> one o_wr_en, o_address=0, all lanes 16'h3C00, o_done 2 cycles after last accept.
REQ-035 Partial word: num_rows=6, base=4, data 16'h3C1F,16'h4533,16'h4700,16'h4233,16'h4900,16'h4000 -> one write at address 4, lanes 0-5 as given in order, lanes 6-15 zero, o_count=6.
REQ-036 Wrap: num_rows=20, base=31 -> writes at address 31 (16 lanes) then 0 (4 lanes, rest zero); exactly two o_wr_en.
REQ-037 Backpressure/gaps: i_valid held high through WRITE cycle plus random idle gaps -> every row appears exactly once in order; no acceptance while o_ready=0.
REQ-038 Corners: num_rows=0 -> DONE, no o_wr_en; i_start during FILL ignored; i_rst mid-FILL -> IDLE, no write; restart from DONE -> new vector correct.
